if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register. It consumes the stall requests from the load-use hazard unit (PC stall, IF/ID stall) and the taken-branch redirect/flush from the branch-resolution stage. It also keeps saturating performance counters for stall and flush cycles.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk_i  input  1  clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
PC_stall_i  input  1  hold PC this cycle (from load-use hazard unit)
IF_ID_stall_i  input  1  hold IF/ID register this cycle (from load-use hazard unit)
branch_taken_i  input  1  taken branch/jump resolved downstream; redirect PC and flush IF/ID
branch_target_i  input  32  redirect address, valid when branch_taken_i=1
IM_instr_i  input  32  instruction read combinationally from IM at IM_addr_o
IM_addr_o  output  32  current PC, driven straight from the PC register
IF_ID_pc_plus4_o  output  32  registered PC+4 of the instruction in ID
IF_ID_instr_o  output  32  registered instruction in ID
IF_ID_valid_o  output  1  1 = IF/ID holds a real instruction, 0 = bubble
stall_cnt_o  output  CNT_W  count of cycles the IF/ID register was held
flush_cnt_o  output  CNT_W  count of redirect/flush events

Behaviour:
- Clock: single domain, clk_i. Reset: asynchronous, active-low (rst_n=0 forces state immediately, without waiting for a clock edge).
- Reset values: PC=PC_RESET, so IM_addr_o=PC_RESET. IF_ID_pc_plus4_o=0, IF_ID_instr_o=0 (NOP), IF_ID_valid_o=0, stall_cnt_o=0, flush_cnt_o=0.
- Reset asserted mid-operation: all state returns to reset values at once. The first fetch after rst_n rises uses PC_RESET.
- PC+4 adder: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). No overflow flag.
- Redirect target: branch_target_i[1:0] is ignored and forced to 2'b00.
- Next-PC priority, evaluated at each rising edge:
  1. branch_taken_i=1 -> PC <= {branch_target_i[31:2],2'b00}
  2. else if PC_stall_i=1 -> PC holds
  3. else PC <= PC+4
- IF/ID register priority, evaluated at each rising edge:
  1. branch_taken_i=1 -> instr<=0, pc_plus4<=0, valid<=0 (bubble)
  2. else if IF_ID_stall_i=1 -> all three fields hold
  3. else instr<=IM_instr_i, pc_plus4<=PC+4, valid<=1
- Simultaneous branch_taken_i and stall: the flush/redirect wins. The stalled instruction is wrong-path and is discarded. The stall does not count toward stall_cnt.
- PC_stall_i and IF_ID_stall_i are honoured independently; the block does no cross-checking. If PC stalls while IF/ID does not, IF/ID reloads the same instruction.
- Fetch latency: an instruction at PC=A appears on IF_ID_instr_o one cycle after IM_addr_o=A, provided there is no stall or flush on that edge.
- stall_cnt_o: +1 on each edge where IF_ID_stall_i=1 and branch_taken_i=0. Saturates at all-ones with no wrap.
- flush_cnt_o: +1 on each edge where branch_taken_i=1. Saturates at all-ones with no wrap.
- No combinational path from any input to any output except IM_addr_o, which is driven straight from the PC register.

Test Plan:
- Reset: hold rst_n=0, then release with PC_RESET=0 and IM returning instr=addr|32'hA000_0000 -> IM_addr_o=0; after edge 1, IF_ID_instr_o=32'hA000_0000, pc_plus4=4, valid=1; after edge 2, IM_addr_o=8.
- Load-use stall: at PC=0x10, assert PC_stall_i=IF_ID_stall_i=1 for 1 cycle -> IM_addr_o stays 0x10 and IF/ID holds instr of 0x0C for one edge; then fetch resumes at 0x10; stall_cnt_o=1.
- Branch: at PC=0x20, branch_taken_i=1, target=0x103 -> next IM_addr_o=0x100, IF_ID_valid_o=0, IF_ID_instr_o=0, flush_cnt_o=1; the following edge loads instr of 0x100 with pc_plus4=0x104.
- Simultaneous: PC_stall_i=IF_ID_stall_i=branch_taken_i=1, target=0x200 -> PC=0x200, bubble in IF/ID, stall_cnt_o unchanged, flush_cnt_o +1.
- Saturation/wrap: with CNT_W=4, apply 20 stall cycles -> stall_cnt_o=4'hF and holds there. With PC_RESET=32'hFFFF_FFF8 -> PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-run: drop rst_n between clock edges while valid=1 -> all outputs return to reset values before the next rising edge.

Source files
------------

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: hazard/redirect controls, IM port, IF/ID register and counters
interface if_stage_if #(
   parameter int CNT_W = 16
) ();
   logic             PC_stall_i;
   logic             IF_ID_stall_i;
   logic             branch_taken_i;
   logic [31:0]      branch_target_i;
   logic [31:0]      IM_instr_i;
   logic [31:0]      IM_addr_o;
   logic [31:0]      IF_ID_pc_plus4_o;
   logic [31:0]      IF_ID_instr_o;
   logic             IF_ID_valid_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport slave (
      input  PC_stall_i, IF_ID_stall_i, branch_taken_i, branch_target_i, IM_instr_i,
      output IM_addr_o, IF_ID_pc_plus4_o, IF_ID_instr_o, IF_ID_valid_o, stall_cnt_o, flush_cnt_o
   );

   modport master (
      output PC_stall_i, IF_ID_stall_i, branch_taken_i, branch_target_i, IM_instr_i,
      input  IM_addr_o, IF_ID_pc_plus4_o, IF_ID_instr_o, IF_ID_valid_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch: PC, IF/ID register, saturating stall/flush counters
module if_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic        clk_i,
   input  logic        rst_n,
   if_stage_if.slave   bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      pc;
   logic [31:0]      pc_plus4;
   logic [31:0]      redirect_pc;
   logic [31:0]      id_instr;
   logic [31:0]      id_pc_plus4;
   logic             id_valid;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [1:0]       unused_target_lsbs;

   assign pc_plus4           = pc + 32'd4;
   assign redirect_pc        = {bus.branch_target_i[31:2], 2'b00};
   assign unused_target_lsbs = bus.branch_target_i[1:0];

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         pc <= PC_RESET;
      end else if (bus.branch_taken_i) begin
         pc <= redirect_pc;
      end else if (!bus.PC_stall_i) begin
         pc <= pc_plus4;
      end
   end

   // A redirect discards whatever was fetched this cycle, even if IF/ID was asked to hold.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         id_instr    <= 32'h0;
         id_pc_plus4 <= 32'h0;
         id_valid    <= 1'b0;
      end else if (bus.branch_taken_i) begin
         id_instr    <= 32'h0;
         id_pc_plus4 <= 32'h0;
         id_valid    <= 1'b0;
      end else if (!bus.IF_ID_stall_i) begin
         id_instr    <= bus.IM_instr_i;
         id_pc_plus4 <= pc_plus4;
         id_valid    <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.IF_ID_stall_i && !bus.branch_taken_i && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (bus.branch_taken_i && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

   assign bus.IM_addr_o        = pc;
   assign bus.IF_ID_instr_o    = id_instr;
   assign bus.IF_ID_pc_plus4_o = id_pc_plus4;
   assign bus.IF_ID_valid_o    = id_valid;
   assign bus.stall_cnt_o      = stall_cnt;
   assign bus.flush_cnt_o      = flush_cnt;
endmodule
